// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// It uses a single req/ack handshake with an error return and byte-lane write strobes.
interface mem_stage_if #(
    parameter int WORD = 64
);
    logic              dmem_req;
    logic              dmem_we;
    logic [WORD-1:0]   dmem_addr;
    logic [WORD-1:0]   dmem_wdata;
    logic [WORD/8-1:0] dmem_wstrb;
    logic              dmem_ack;
    logic              dmem_err;
    logic [WORD-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ack, dmem_err, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ack, dmem_err, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access and branch-resolution stage. It captures the execute results on start,
// performs at most one bus access, and reports load data and the branch decision with done.
module mem_stage #(
    parameter int WORD    = 64,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [1:0]      size,
    input  logic            branch_zero,
    input  logic            branch_nzero,
    input  logic            uncond_branch,
    input  logic            cond_branch,
    input  logic [3:0]      cond,
    input  logic [WORD-1:0] alu_result,
    input  logic [WORD-1:0] write_data,
    input  logic [WORD-1:0] branch_target,
    input  logic            alu_zero,
    input  logic            negative,
    input  logic            zero,
    input  logic            carry,
    input  logic            overflow,
    mem_stage_if.master     dmem,
    output logic [WORD-1:0] read_data,
    output logic            pc_src,
    output logic [WORD-1:0] pc_target,
    output logic            done,
    output logic            busy,
    output logic            fault
);

    localparam int LANES = WORD / 8;
    localparam int CW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    off_q;
    logic [1:0]    size_q;
    logic          load_q, we_q, fault_q;

    // The even condition codes test a base predicate.
    // The odd codes below 1110 test its inverse.
    function automatic logic cond_holds(input logic [3:0] cc, input logic n, z, c, v);
        logic base;
        case (cc[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (cc[3:1] == 3'b111) ? 1'b1 : (base ^ cc[0]);
    endfunction

    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return LANES'(8'h01);
            2'b01:   return LANES'(8'h03);
            2'b10:   return LANES'(8'h0F);
            default: return LANES'(8'hFF);
        endcase
    endfunction

    function automatic logic [WORD-1:0] data_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return WORD'(64'hFF);
            2'b01:   return WORD'(64'hFFFF);
            2'b10:   return WORD'(64'hFFFF_FFFF);
            default: return '1;
        endcase
    endfunction

    logic [2:0] offset;
    logic       misaligned, illegal, go_access, branch_take, timed_out;

    assign offset      = alu_result[2:0];
    assign illegal     = (mem_read & mem_write) | ((mem_read | mem_write) & misaligned);
    assign go_access   = (mem_read ^ mem_write) & ~misaligned;
    assign branch_take = uncond_branch | (branch_zero & alu_zero) | (branch_nzero & ~alu_zero)
                       | (cond_branch & cond_holds(cond, negative, zero, carry, overflow));
    assign timed_out   = ~dmem.dmem_ack & (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = |offset[1:0];
            default: misaligned = |offset;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // Every register then updates from pre-edge values, whatever order the blocks appear in.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case statement.
    // Any path that does not assign it therefore cannot infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = go_access ? ACCESS : DONE;
            ACCESS:  if (dmem.dmem_ack || dmem.dmem_err || timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign done          = (state == DONE);
    assign busy          = (state != IDLE);
    assign fault         = done & fault_q;
    assign dmem.dmem_req = (state == ACCESS);
    assign dmem.dmem_we  = we_q & (state == ACCESS);

    always_ff @(posedge clk) begin
        if (reset) begin
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_wstrb <= '0;
            read_data       <= '0;
            pc_src          <= 1'b0;
            pc_target       <= '0;
            cnt             <= '0;
            off_q           <= '0;
            size_q          <= '0;
            load_q          <= 1'b0;
            we_q            <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dmem.dmem_addr  <= {alu_result[WORD-1:3], 3'b000};
                    dmem.dmem_wdata <= write_data << {offset, 3'b000};
                    dmem.dmem_wstrb <= lane_mask(size) << offset;
                    off_q           <= offset;
                    size_q          <= size;
                    load_q          <= mem_read & ~mem_write;
                    we_q            <= mem_write & ~mem_read;
                    fault_q         <= illegal;
                    pc_src          <= branch_take & ~illegal;
                    pc_target       <= branch_target;
                    cnt             <= '0;
                    if (mem_read && illegal) read_data <= '0;
                end
                ACCESS: begin
                    cnt <= cnt + CW'(1);
                    // A bus error beats a simultaneous ack; any abort clears a pending load.
                    if (dmem.dmem_err || timed_out) begin
                        fault_q <= 1'b1;
                        pc_src  <= 1'b0;
                        if (load_q) read_data <= '0;
                    end else if (dmem.dmem_ack && load_q) begin
                        read_data <= (dmem.dmem_rdata >> {off_q, 3'b000}) & data_mask(size_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, multi-cycle corner sequences,
// then random transactions checked against a behavioural model of the stage.
module tb_mem_stage;
    localparam int WORD    = 64;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, mem_read, mem_write;
    logic [1:0]  size;
    logic        branch_zero, branch_nzero, uncond_branch, cond_branch;
    logic [3:0]  cond;
    logic [63:0] alu_result, write_data, branch_target;
    logic        alu_zero, negative, zero, carry, overflow;
    logic [63:0] read_data, pc_target;
    logic        pc_src, done, busy, fault;

    always #5 clk = ~clk;

    mem_stage_if #(.WORD(WORD)) bus ();

    mem_stage #(.WORD(WORD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_read(mem_read), .mem_write(mem_write),
        .size(size), .branch_zero(branch_zero), .branch_nzero(branch_nzero),
        .uncond_branch(uncond_branch), .cond_branch(cond_branch), .cond(cond),
        .alu_result(alu_result), .write_data(write_data), .branch_target(branch_target),
        .alu_zero(alu_zero), .negative(negative), .zero(zero), .carry(carry),
        .overflow(overflow), .dmem(bus), .read_data(read_data), .pc_src(pc_src),
        .pc_target(pc_target), .done(done), .busy(busy), .fault(fault)
    );

    typedef enum {R_ACK, R_ERR, R_BOTH, R_NONE} resp_t;

    typedef struct {
        logic        rd, wr;
        logic [1:0]  size;
        logic [63:0] addr, wdata, target, rdata;
        logic        bz, bnz, ub, cb;
        logic [3:0]  cond;
        logic        n, z, c, v, az;
        resp_t       resp;
        int          delay;
    } txn_t;

    typedef struct {
        int          lat, reqs;
        logic        flt, pc;
        logic [63:0] rd;
    } exp_t;

    typedef struct {
        int          lat, reqs;
        logic        flt, pc, we, busy;
        logic [63:0] rd, tgt, addr, wdata;
        logic [7:0]  strb;
    } obs_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] model_rd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cond_model(input logic [3:0] cc, input logic n, z, c, v);
        case (cc)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return c && !z;
            4'd9:    return !(c && !z);
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] model_strb(input txn_t t);
        int bytes = 1 << t.size;
        int m     = ((1 << bytes) - 1) << t.addr[2:0];
        return m[7:0];
    endfunction

    function automatic exp_t model(input txn_t t, input logic [63:0] prev_rd);
        exp_t        e;
        int          bytes = 1 << t.size;
        logic        is_mem = t.rd || t.wr;
        logic        bad = (t.rd && t.wr) || (is_mem && (t.addr % bytes) != 0);
        logic [63:0] mask = (bytes == 8) ? '1 : ((64'd1 << (8 * bytes)) - 1);
        e.rd = prev_rd;
        if (!is_mem || bad) begin
            e.lat = 1; e.reqs = 0; e.flt = bad;
        end else if (t.resp == R_NONE || t.delay >= TIMEOUT) begin
            e.lat = 1 + TIMEOUT; e.reqs = TIMEOUT; e.flt = 1'b1;
        end else begin
            e.lat = 2 + t.delay; e.reqs = t.delay + 1; e.flt = (t.resp != R_ACK);
        end
        if (t.rd && e.flt) e.rd = '0;
        else if (t.rd && !t.wr) e.rd = (t.rdata >> (8 * t.addr[2:0])) & mask;
        e.pc = !e.flt && (t.ub || (t.bz && t.az) || (t.bnz && !t.az) ||
                          (t.cb && cond_model(t.cond, t.n, t.z, t.c, t.v)));
        return e;
    endfunction

    task automatic drive_txn(input txn_t t);
        mem_read = t.rd; mem_write = t.wr; size = t.size; alu_result = t.addr;
        write_data = t.wdata; branch_target = t.target; branch_zero = t.bz;
        branch_nzero = t.bnz; uncond_branch = t.ub; cond_branch = t.cb; cond = t.cond;
        negative = t.n; zero = t.z; carry = t.c; overflow = t.v; alu_zero = t.az;
    endtask

    task automatic scramble_inputs();
        mem_read = 1'($urandom); mem_write = 1'($urandom); size = 2'($urandom);
        alu_result = {$urandom, $urandom}; write_data = {$urandom, $urandom};
        branch_target = {$urandom, $urandom}; cond = 4'($urandom);
        {branch_zero, branch_nzero, uncond_branch, cond_branch} = 4'($urandom);
        {negative, zero, carry, overflow, alu_zero} = 5'($urandom);
    endtask

    // Issue one transaction, play the memory side, and observe until done (bounded).
    task automatic run_txn(input txn_t t, output obs_t o);
        logic hit;
        o.lat = 0; o.reqs = 0; o.flt = 0; o.pc = 0; o.we = 0; o.busy = 0;
        o.rd = 0; o.tgt = 0; o.addr = 0; o.wdata = 0; o.strb = 0;
        @(negedge clk);
        drive_txn(t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        o.lat = 1;
        while (!done && o.lat <= 40) begin
            if (bus.dmem_req) begin
                if (o.reqs == 0) begin
                    o.addr = bus.dmem_addr; o.wdata = bus.dmem_wdata;
                    o.strb = bus.dmem_wstrb; o.we = bus.dmem_we; o.busy = busy;
                end
                hit = (o.reqs == t.delay);
                bus.dmem_ack   = hit && (t.resp == R_ACK || t.resp == R_BOTH);
                bus.dmem_err   = hit && (t.resp == R_ERR || t.resp == R_BOTH);
                bus.dmem_rdata = hit ? t.rdata : {$urandom, $urandom};
                o.reqs++;
            end else begin
                bus.dmem_ack = 1'b0;
                bus.dmem_err = 1'b0;
            end
            @(negedge clk);
            o.lat++;
        end
        bus.dmem_ack = 1'b0;
        bus.dmem_err = 1'b0;
        o.flt = fault; o.rd = read_data; o.pc = pc_src; o.tgt = pc_target;
    endtask

    task automatic check_result(input string tag, input txn_t t, input exp_t e, input obs_t o);
        logic [7:0]  es;
        logic [63:0] bm;
        check({tag, " latency"}, 64'(o.lat), 64'(e.lat));
        check({tag, " req_cycles"}, 64'(o.reqs), 64'(e.reqs));
        check({tag, " fault"}, 64'(o.flt), 64'(e.flt));
        check({tag, " read_data"}, o.rd, e.rd);
        check({tag, " pc_src"}, 64'(o.pc), 64'(e.pc));
        check({tag, " pc_target"}, o.tgt, t.target);
        if (e.reqs > 0 && o.reqs > 0) begin
            check({tag, " dmem_addr"}, o.addr, {t.addr[63:3], 3'b000});
            check({tag, " dmem_we"}, 64'(o.we), 64'(t.wr));
            check({tag, " busy"}, 64'(o.busy), 64'd1);
            if (t.wr) begin
                es = model_strb(t);
                bm = '0;
                for (int i = 0; i < 8; i++) bm[8*i +: 8] = {8{es[i]}};
                check({tag, " dmem_wstrb"}, 64'(o.strb), 64'(es));
                check({tag, " dmem_wdata"}, o.wdata & bm, (t.wdata << (8 * t.addr[2:0])) & bm);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        txn_t z, t;
        obs_t o;
        exp_t e;

        z = '{rd: 0, wr: 0, size: 0, addr: 0, wdata: 0, target: 0, rdata: 0, bz: 0, bnz: 0,
              ub: 0, cb: 0, cond: 0, n: 0, z: 0, c: 0, v: 0, az: 0, resp: R_ACK, delay: 0};
        for (int i = 0; i < 14; i++) vecs[i].t = z;
        vecs[0].t.target = 64'h1000;
        vecs[0].e = '{lat: 1, reqs: 0, flt: 0, pc: 0, rd: 64'h0};
        vecs[1].t.rd = 1; vecs[1].t.size = 3; vecs[1].t.addr = 64'h40; vecs[1].t.delay = 2;
        vecs[1].t.rdata = 64'h1122334455667788;
        vecs[1].e = '{lat: 4, reqs: 3, flt: 0, pc: 0, rd: 64'h1122334455667788};
        vecs[2].t.wr = 1; vecs[2].t.size = 0; vecs[2].t.addr = 64'h45; vecs[2].t.wdata = 64'hAB;
        vecs[2].e = '{lat: 2, reqs: 1, flt: 0, pc: 0, rd: 64'h1122334455667788};
        vecs[3].t.wr = 1; vecs[3].t.size = 1; vecs[3].t.addr = 64'h43;
        vecs[3].e = '{lat: 1, reqs: 0, flt: 1, pc: 0, rd: 64'h1122334455667788};
        vecs[4].t.rd = 1; vecs[4].t.size = 3; vecs[4].t.addr = 64'h80; vecs[4].t.resp = R_NONE;
        vecs[4].e = '{lat: 17, reqs: 16, flt: 1, pc: 0, rd: 64'h0};
        vecs[5].t.cb = 1; vecs[5].t.cond = 4'b1100; vecs[5].t.n = 1; vecs[5].t.v = 1;
        vecs[5].t.target = 64'h2000;
        vecs[5].e = '{lat: 1, reqs: 0, flt: 0, pc: 1, rd: 64'h0};
        vecs[6].t = vecs[5].t; vecs[6].t.z = 1;
        vecs[6].e = '{lat: 1, reqs: 0, flt: 0, pc: 0, rd: 64'h0};
        vecs[7].t.bnz = 1; vecs[7].t.az = 0; vecs[7].t.target = 64'hDEAD_BEEF_00;
        vecs[7].e = '{lat: 1, reqs: 0, flt: 0, pc: 1, rd: 64'h0};
        vecs[8].t.rd = 1; vecs[8].t.size = 1; vecs[8].t.addr = 64'h46;
        vecs[8].t.rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        vecs[8].e = '{lat: 2, reqs: 1, flt: 0, pc: 0, rd: 64'hAAAA};
        vecs[9].t.rd = 1; vecs[9].t.size = 2; vecs[9].t.addr = 64'h44; vecs[9].t.delay = 15;
        vecs[9].t.rdata = 64'h0123_4567_89AB_CDEF;
        vecs[9].e = '{lat: 17, reqs: 16, flt: 0, pc: 0, rd: 64'h0123_4567};
        vecs[10].t.rd = 1; vecs[10].t.size = 3; vecs[10].t.addr = 64'h48; vecs[10].t.delay = 1;
        vecs[10].t.resp = R_BOTH; vecs[10].t.ub = 1; vecs[10].t.rdata = 64'h77;
        vecs[10].e = '{lat: 3, reqs: 2, flt: 1, pc: 0, rd: 64'h0};
        vecs[11].t.rd = 1; vecs[11].t.wr = 1; vecs[11].t.addr = 64'h10; vecs[11].t.ub = 1;
        vecs[11].e = '{lat: 1, reqs: 0, flt: 1, pc: 0, rd: 64'h0};
        vecs[12].t.rd = 1; vecs[12].t.size = 0; vecs[12].t.addr = 64'h47;
        vecs[12].t.rdata = 64'h9A00_0000_0000_0000;
        vecs[12].e = '{lat: 2, reqs: 1, flt: 0, pc: 0, rd: 64'h9A};
        vecs[13].t.wr = 1; vecs[13].t.size = 2; vecs[13].t.addr = 64'h4;
        vecs[13].t.wdata = 64'hCAFE_F00D; vecs[13].t.bz = 1; vecs[13].t.az = 1;
        vecs[13].e = '{lat: 2, reqs: 1, flt: 0, pc: 1, rd: 64'h9A};

        reset = 1'b1; start = 1'b0;
        drive_txn(z);
        bus.dmem_ack = 1'b0; bus.dmem_err = 1'b0; bus.dmem_rdata = '0;
        @(negedge clk);
        check("reset done", 64'(done), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset fault", 64'(fault), 64'd0);
        check("reset pc_src", 64'(pc_src), 64'd0);
        check("reset dmem_req", 64'(bus.dmem_req), 64'd0);
        check("reset dmem_we", 64'(bus.dmem_we), 64'd0);
        check("reset dmem_wstrb", 64'(bus.dmem_wstrb), 64'd0);
        check("reset dmem_addr", bus.dmem_addr, 64'd0);
        check("reset dmem_wdata", bus.dmem_wdata, 64'd0);
        check("reset read_data", read_data, 64'd0);
        check("reset pc_target", pc_target, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i].t, o);
            check_result($sformatf("vec%0d", i), vecs[i].t, vecs[i].e, o);
        end

        // A start pulse while a load is outstanding must be ignored.
        t = z; t.rd = 1; t.size = 3; t.addr = 64'h100;
        @(negedge clk);
        drive_txn(t); start = 1'b1;
        @(negedge clk);
        t = z; t.wr = 1; t.addr = 64'h7; t.ub = 1;
        drive_txn(t); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start dmem_addr", bus.dmem_addr, 64'h100);
        check("busy_start dmem_we", 64'(bus.dmem_we), 64'd0);
        check("busy_start dmem_req", 64'(bus.dmem_req), 64'd1);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'h55;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        check("busy_start done", 64'(done), 64'd1);
        check("busy_start read_data", read_data, 64'h55);
        check("busy_start pc_src", 64'(pc_src), 64'd0);
        @(negedge clk);
        check("busy_start no extra done", 64'(done), 64'd0);

        // Reset during ACCESS drops the request; a late ack in IDLE is ignored.
        t = z; t.rd = 1; t.size = 3; t.addr = 64'h200;
        drive_txn(t); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_access dmem_req before", 64'(bus.dmem_req), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_access dmem_req after", 64'(bus.dmem_req), 64'd0);
        check("rst_access busy", 64'(busy), 64'd0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_access late ack done%0d", i), 64'(done), 64'd0);
        end
        bus.dmem_ack = 1'b0;
        check("rst_access read_data", read_data, 64'd0);

        // Reset wins over a simultaneous start.
        drive_txn(z); reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_start done", 64'(done), 64'd0);
        check("rst_start busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("rst_start done later", 64'(done), 64'd0);
        model_rd = '0;

        for (int i = 0; i < 300; i++) begin
            t = z;
            t.rd = 1'($urandom); t.wr = 1'($urandom_range(0, 5) == 0) | (!t.rd && 1'($urandom));
            t.size = 2'($urandom);
            t.addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~((64'd1 << t.size) - 1);
            t.wdata = {$urandom, $urandom}; t.target = {$urandom, $urandom};
            t.rdata = {$urandom, $urandom};
            {t.bz, t.bnz, t.ub, t.cb} = 4'(1 << $urandom_range(0, 4));
            t.cond = 4'($urandom);
            {t.n, t.z, t.c, t.v, t.az} = 5'($urandom);
            t.resp = resp_t'($urandom_range(0, 6) > 3 ? $urandom_range(1, 3) : 0);
            t.delay = $urandom_range(0, 17);
            e = model(t, model_rd);
            run_txn(t, o);
            check_result($sformatf("rnd%0d", i), t, e, o);
            model_rd = e.rd;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access and branch-resolution stage that sits directly downstream of the execute stage. On a one-cycle `start` pulse it captures the ALU result, store data, branch target and condition flags produced by execute. It then performs at most one data-memory access over a req/ack bus and resolves the branch decision. It returns load data, `pc_src` and the branch target with a one-cycle `done` pulse.

## Interface
- `WORD`, 64: datapath width. The bus is always WORD bits, with WORD/8 byte lanes.
- `TIMEOUT`, 16: maximum number of cycles `dmem_req` is held without `dmem_ack` before a fault is raised.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; execute outputs are valid this cycle.
- `mem_read`, `mem_write`  in  1 each  load / store. Both high counts as a fault.
- `size`  in  2  access size: 00 byte, 01 half, 10 word (32), 11 double.
- `branch_zero`, `branch_nzero`, `uncond_branch`, `cond_branch`  in  1 each  CBZ / CBNZ / B / B.cond.
- `cond`  in  4  B.cond condition code.
- `alu_result`  in  WORD  effective address.
- `write_data`  in  WORD  store data, from execute's `read_data2`.
- `branch_target`  in  WORD  from execute's `branch_alu_result`.
- `alu_zero`  in  1  zero flag used by CBZ/CBNZ.
- `negative`, `zero`, `carry`, `overflow`  in  1 each  status-register flags used by B.cond.
- `dmem_req`, `dmem_we`  out  1 each  bus request / write enable.
- `dmem_addr`  out  WORD  `alu_result` with bits [2:0] cleared.
- `dmem_wdata`  out  WORD  lane-shifted store data.
- `dmem_wstrb`  out  WORD/8  byte-lane enables.
- `dmem_ack`, `dmem_err`  in  1 each  completion / bus error, sampled only while `dmem_req` is high.
- `dmem_rdata`  in  WORD  read data, valid with `dmem_ack`.
- `read_data`  out  WORD  zero-extended load result.
- `pc_src`  out  1  take the branch.
- `pc_target`  out  WORD  registered `branch_target`.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high when state is not IDLE.
- `fault`  out  1  high with `done` when the access was aborted.

## Operation
- States: IDLE, ACCESS, DONE. Reset forces IDLE and drives every output to 0.
- **IDLE**
  - On `start`, register all inputs.
  - Go to ACCESS if exactly one of `mem_read` / `mem_write` is high and the address is aligned. Otherwise go to DONE.
  - `start` while `busy` is ignored.
- **Alignment rule:** the access must be naturally aligned.
  - Half: `addr[0]`=0.
  - Word: `addr[1:0]`=0.
  - Double: `addr[2:0]`=0.
  - A misaligned access, or both `mem_read` and `mem_write` high, goes directly to DONE with `fault`=1 and issues no bus request.
- **ACCESS**
  - `dmem_req`=1, and `dmem_addr`, `dmem_we`, `dmem_wstrb` and `dmem_wdata` are held stable.
  - On `dmem_ack`: for a load, capture `(dmem_rdata >> 8*addr[2:0])` masked to the access size into `read_data`. Then go to DONE.
  - On `dmem_err`: go to DONE with `fault`=1. `dmem_err` has priority over a simultaneous `dmem_ack`.
  - A cycle counter starts at 0 on the first req cycle. If `dmem_ack`/`dmem_err` is not seen by counter value TIMEOUT-1, go to DONE with `fault`=1 and drop `dmem_req`.
- **Write lanes**
  - `dmem_wstrb` = size mask shifted left by `addr[2:0]`. Size masks: byte 0x01, half 0x03, word 0x0F, double 0xFF.
  - `dmem_wdata` = `write_data << 8*addr[2:0]`. Bytes outside the strobe mask are don't-care.
- **DONE**
  - `done`=1 for exactly one cycle, then return to IDLE.
  - `read_data` holds its value until the next load completes. It is 0 after a faulted load.
- **Branch decision** (registered at `start`):
  - `pc_src` = `uncond_branch` | (`branch_zero` & `alu_zero`) | (`branch_nzero` & !`alu_zero`) | (`cond_branch` & condition true).
  - `fault` forces `pc_src`=0.
- **Condition codes** (using N, Z, C, V):
  - EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !(C&!Z).
  - GE N==V; LT N!=V; GT !Z&(N==V); LE !(!Z&(N==V)).
  - 1110 and 1111 are always true.
- `pc_src` and `pc_target` are valid during `done` and held until the next `start`.

## Timing
- **Non-memory instruction:** `start` at cycle T gives `done` at T+1.
- **Memory access:** `start` at T raises `dmem_req` at T+1.
  - Ack sampled at T+1+k (k≥0) gives `done` at T+2+k.
  - `dmem_req` falls at T+2+k.
- **Timeout:** `done` and `fault` at T+1+TIMEOUT.
- **Reset in ACCESS:** `dmem_req` is 0 the cycle after reset, and no `done` is produced. A late `dmem_ack` in IDLE is ignored.
- **Reset asserted together with `start`:** reset wins.
- Back-to-back `start` is accepted in the cycle after `done`, with state IDLE.

## Test plan
- ADD-class instruction (no mem, no branch), `start` at T: `done`=1 at T+1; `pc_src`=0; `dmem_req` never high.
- LDUR double at `addr`=0x40, ack on the 3rd req cycle with `rdata`=0x1122334455667788: `dmem_addr`=0x40; `done` at T+4; `read_data`=0x1122334455667788.
- STURB at `addr`=0x45 with `write_data`=0xAB, ack immediately:
  - `dmem_wstrb`=0x20.
  - `dmem_wdata[47:40]`=0xAB.
  - `dmem_we`=1.
  - `done` at T+2.
- STURH at `addr`=0x43: no bus request; `done` and `fault` at T+1.
- Timeout: LDUR with no ack, TIMEOUT=16: `dmem_req` high for T+1..T+16; `done`/`fault` at T+17; `read_data`=0.
- B.cond GT with N=1, V=1, Z=0: `pc_src`=1. Same test with Z=1: `pc_src`=0. CBNZ with `alu_zero`=0: `pc_src`=1 and `pc_target`=`branch_target`.
